palette_lut_dbuf: RTL
=====================

// Module: palette_lut_dbuf
// PURPOSE
//  Runtime-writable, double-buffered colour palette for the VGA sprite/background path.
//  Maps a per-pixel colour index to RGB through a 2-stage pipeline.
//  Writes go to a shadow bank, which becomes active only at a frame boundary,
//  so palette changes never tear mid-frame. Sits between the sprite ROM index
//  output and the VGA colour mapper.
// PARAMETERS
//  IDX_W    4  colour index width; each bank holds DEPTH = 2**IDX_W entries
//  COLOR_W  4  bits per colour channel; entry width = 3*COLOR_W, packed {R,G,B}
// PORTS
//  Clk           in   1          system clock; all logic on rising edge
//  Reset         in   1          synchronous, active-high reset
//  pix_index     in   IDX_W      colour index for the current pixel
//  pix_in_valid  in   1          pix_index is a real pixel this cycle
//  blank         in   1          pixel is outside the visible area; force black
//  wr_en         in   1          write one shadow-bank entry this cycle
//  wr_addr       in   IDX_W      shadow entry to write
//  wr_data       in   3*COLOR_W  {R,G,B} written to shadow[wr_addr]
//  swap_req      in   1          request a bank swap at the next frame_start
//  frame_start   in   1          one-cycle pulse at the start of a frame (vsync edge)
//  red/green/blue out COLOR_W    looked-up colour, registered
//  pix_valid     out  1          red/green/blue correspond to a pixel_in_valid 2 cycles ago
//  swap_pending  out  1          swap requested and not yet taken
//  active_bank   out  1          bank currently used for lookup (0/1)
// BEHAVIOUR
//  Storage: 2 banks x DEPTH x 3*COLOR_W flops. active_bank selects the lookup bank;
//   the shadow bank is ~active_bank.
//  Reset (Clk edge with Reset=1): all entries of both banks = 0; active_bank = 0;
//   swap_pending = 0; pipeline valids = 0; red/green/blue = 0; pix_valid = 0.
//   Reset overrides every other input in that cycle.
//  Write: wr_en=1 -> shadow[wr_addr] <= wr_data at the edge. The shadow bank is
//   judged by active_bank BEFORE the edge. The active bank is never written.
//  Swap request: swap_req=1 sets swap_pending. Further requests while pending are
//   ignored (the flag is sticky, not a counter).
//  Swap: at an edge where frame_start=1 and (swap_pending | swap_req):
//   - active_bank toggles;
//   - swap_pending <= 0.
//   frame_start without a pending or same-cycle request: no change.
//  Simultaneous write + swap edge: the write lands in the old shadow bank, which
//   is the new active bank. That entry is visible to lookups from the next cycle.
//  The new shadow (old active) keeps its contents; there is no copy or clear.
//  Pipeline (latency 2, throughput 1/cycle, no stall):
//   S1: register pix_index, pix_in_valid, blank.
//   S2: {red,green,blue} <= (S1.blank | ~S1.valid) ? 0 : bank[active_bank][S1.index].
//       pix_valid <= S1.valid.
//   S2 reads active_bank as of that edge (pre-swap value). Pixels already in S1
//   at a swap edge use the old bank; pixels entering S1 at that edge use the new bank.
//  Outputs hold their last value only while the pipeline keeps feeding them. A
//   cycle with pix_in_valid=0 produces 0 colour and pix_valid=0 two cycles later.
//  Write-to-read: writes never affect red/green/blue until a swap has occurred.
// TESTING
//  1. Reset, then index 5 valid, blank=0 -> 2 cycles later RGB=0,0,0, pix_valid=1,
//     active_bank=0.
//  2. Write shadow[3]=12'hDCA; no swap; look up 3 -> RGB=0. Then swap_req + frame_start
//     -> active_bank=1, swap_pending=0; look up 3 -> R=D,G=C,B=A after 2 cycles.
//  3. swap_req at cycle 10, frame_start at cycle 50 -> swap_pending=1 for cycles
//     11..50, active_bank toggles at the cycle-50 edge; continuous lookup stream
//     shows the colour change exactly on the pixel entering S1 at cycle 50.
//  4. Same-edge wr_en (addr 7, 12'h963) + swap -> index 7 reads 9,6,3 from the first
//     lookup after the swap.
//  5. blank=1 with index 3 (active entry DCA) -> RGB=0, pix_valid=1; pix_in_valid=0
//     -> RGB=0, pix_valid=0.
//  6. Reset asserted mid-stream with swap_pending=1 and active_bank=1 -> next cycle
//     all outputs 0, active_bank=0, all entries read 0.

Source files
------------

// File: rtl/palette_lut_dbuf.sv
// Double-buffered colour palette: index -> {R,G,B} through a 2-stage pipeline.
// Writes land in the shadow bank; banks swap only on a frame_start pulse.
module palette_lut_dbuf #(
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [IDX_W-1:0]     pix_index,
  input  logic                 pix_in_valid,
  input  logic                 blank,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [3*COLOR_W-1:0] wr_data,
  input  logic                 swap_req,
  input  logic                 frame_start,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 pix_valid,
  output logic                 swap_pending,
  output logic                 active_bank
);

  localparam int DEPTH   = 2 ** IDX_W;
  localparam int ENTRY_W = 3 * COLOR_W;

  logic [ENTRY_W-1:0] bank_q [2][DEPTH];
  logic [ENTRY_W-1:0] bank_d [2][DEPTH];

  logic               active_bank_q, active_bank_d;
  logic               swap_pending_q, swap_pending_d;

  logic [IDX_W-1:0]   s1_index_q, s1_index_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_blank_q, s1_blank_d;

  logic [ENTRY_W-1:0] rgb_q, rgb_d;
  logic               pix_valid_q, pix_valid_d;

  logic               swap_now;

  // NOTE: every variable written here gets a default first, so no path
  // through the block can leave a value unassigned and infer a latch.
  always_comb begin
    bank_d = bank_q;
    if (wr_en) begin
      bank_d[~active_bank_q][wr_addr] = wr_data;
    end

    // A same-cycle request counts, so swap_req and frame_start may coincide.
    swap_now       = frame_start & (swap_pending_q | swap_req);
    active_bank_d  = active_bank_q ^ swap_now;
    swap_pending_d = swap_now ? 1'b0 : (swap_pending_q | swap_req);

    s1_index_d = pix_index;
    s1_valid_d = pix_in_valid;
    s1_blank_d = blank;

    // Lookup uses the bank active before this edge; a swap takes effect
    // for the pixel entering S1 on the same edge.
    rgb_d       = (s1_blank_q | ~s1_valid_q) ? '0 : bank_q[active_bank_q][s1_index_q];
    pix_valid_d = s1_valid_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: the palette storage is flops, not RAM, and must read as all-zero
      // after reset, so it is cleared here along with the control state.
      bank_q         <= '{default: '0};
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      s1_index_q     <= '0;
      s1_valid_q     <= 1'b0;
      s1_blank_q     <= 1'b0;
      rgb_q          <= '0;
      pix_valid_q    <= 1'b0;
    end else begin
      bank_q         <= bank_d;
      active_bank_q  <= active_bank_d;
      swap_pending_q <= swap_pending_d;
      s1_index_q     <= s1_index_d;
      s1_valid_q     <= s1_valid_d;
      s1_blank_q     <= s1_blank_d;
      rgb_q          <= rgb_d;
      pix_valid_q    <= pix_valid_d;
    end
  end

  assign red          = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign green        = rgb_q[2*COLOR_W-1:COLOR_W];
  assign blue         = rgb_q[COLOR_W-1:0];
  assign pix_valid    = pix_valid_q;
  assign swap_pending = swap_pending_q;
  assign active_bank  = active_bank_q;

endmodule
